if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch stage. Successor to the single-register PC/inst fetch stage.
- Owns the fetch PC and issues requests to a 1-cycle-latency instruction ROM.
- Buffers returned {pc, inst} pairs in a DEPTH-entry FIFO and presents them to decode with a valid/ready handshake.
- Redirect sources are prioritised: interrupt, then execute redirect, then branch-predictor token.

Parameters:
- RESET_PC, 32'hbfc00000, fetch PC loaded on reset.
- DEPTH, 4, fetch-queue entries; power of two, 2..16.
- PC_W, 32, PC width.
- INST_W, 32, instruction width.
- PC_STEP, 4, sequential PC increment.

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- irom_req_o  out  1  ROM read request this cycle.
- irom_pc_o  out  PC_W  ROM read address; equals fetch PC.
- irom_inst_i  in  INST_W  ROM data, valid the cycle after an accepted request.
- int_req_i  in  1  interrupt redirect.
- int_pc_i  in  PC_W  interrupt target.
- ex_redirect_i  in  1  execute/writeback branch redirect.
- ex_pc_i  in  PC_W  redirect target.
- bp_token_i  in  1  predictor-taken redirect.
- bp_pc_i  in  PC_W  predicted target.
- id_valid_o  out  1  queue head valid to decode.
- id_ready_i  in  1  decode accepts head.
- id_pc_o  out  PC_W  head PC.
- id_pc_4_o  out  PC_W  head PC + PC_STEP, modulo 2^PC_W.
- id_inst_o  out  INST_W  head instruction.
- q_count_o  out  clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async, resetn=0): fpc=RESET_PC, queue empty, count=0, no request in flight. id_valid_o=0, irom_req_o=0, id_pc_o/id_inst_o=0.
- Redirect select: redir = int_req_i | ex_redirect_i | bp_token_i. Target = int_pc_i if int_req_i, else ex_pc_i if ex_redirect_i, else bp_pc_i.
- Issue: irom_req_o = resetn & !redir & (count + inflight < DEPTH), where inflight is the registered "request issued last cycle" flag. This credit rule guarantees a response never meets a full queue.
- On an issued cycle: fpc <= fpc + PC_STEP. The issued PC is registered as the in-flight tag.
- Response: in the cycle after an issue, {tag, irom_inst_i} is enqueued at the next edge. It becomes the head no earlier than the following cycle.
- Dequeue: occurs at the edge when id_valid_o & id_ready_i. Simultaneous enqueue and dequeue is legal and leaves count unchanged.
- id_valid_o = (count != 0) & !redir. The head is never consumed in a redirect cycle.
- Redirect in cycle N:
  - At edge N: queue flushed (count=0), the in-flight response due at N+1 is discarded, fpc <= target.
  - Cycle N+1: irom_req_o=1, irom_pc_o=target.
  - Cycle N+3: id_valid_o=1 with id_pc_o=target. Redirect-to-decode latency is 3 cycles.
- Back-to-back redirects: the latest wins. Each redirect discards all older work.
- Stall (id_ready_i=0): the queue fills to DEPTH, then irom_req_o drops. Head outputs stay stable until accepted.
- Queue output ordering: strictly fetch order. No entry is duplicated or dropped except on a flush.
- PC wrap: fpc + PC_STEP wraps modulo 2^PC_W with no flag.
- Reset asserted mid-operation clears all state immediately, including the in-flight tag.
- Steady-state throughput with id_ready_i=1: one instruction per cycle.

Test Plan:
1. Reset release with ROM returning inst = PC ^ 32'h5a5a5a5a and id_ready=1 -> irom_pc_o sequence bfc00000, bfc00004, ... First id_valid appears 2 cycles after the first request, with id_pc_o=bfc00000 and id_pc_4_o=bfc00004. Then one instruction per cycle, in order.
2. id_ready=0 for 10 cycles with DEPTH=4 -> q_count_o saturates at 4 and irom_req_o=0. On release, heads bfc00000..bfc0000c drain in order, then bfc00010 follows with no gap or duplicate.
3. ex_redirect_i=1, ex_pc_i=80001000 for one cycle with 3 entries queued -> q_count_o=0 next cycle, the in-flight response is discarded, irom_pc_o=80001000. id_pc_o=80001000 valid 3 cycles after the redirect.
4. int_req_i, ex_redirect_i and bp_token_i asserted together with targets bfc00380, 80002000, 80003000 -> next irom_pc_o=bfc00380. id_valid_o=0 during the redirect cycle.
5. Redirect to fffffffc -> fetch sequence fffffffc, 00000000. id_pc_4_o for the head fffffffc is 00000000.
6. resetn pulsed low mid-stream with a full queue -> outputs clear asynchronously. After release, fetching restarts at bfc00000.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, reads a 1-cycle ROM and
// queues {pc, inst} pairs for decode behind a valid/ready handshake.
module if_fetch_queue #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INST_W   = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     PC_STEP  = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'hbfc00000
) (
  input  logic                       clk,
  input  logic                       resetn,
  output logic                       irom_req_o,
  output logic [PC_W-1:0]            irom_pc_o,
  input  logic [INST_W-1:0]          irom_inst_i,
  input  logic                       int_req_i,
  input  logic [PC_W-1:0]            int_pc_i,
  input  logic                       ex_redirect_i,
  input  logic [PC_W-1:0]            ex_pc_i,
  input  logic                       bp_token_i,
  input  logic [PC_W-1:0]            bp_pc_i,
  output logic                       id_valid_o,
  input  logic                       id_ready_i,
  output logic [PC_W-1:0]            id_pc_o,
  output logic [PC_W-1:0]            id_pc_4_o,
  output logic [INST_W-1:0]          id_inst_o,
  output logic [$clog2(DEPTH):0]     q_count_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned CW1 = CW + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ent_t;

  logic [PC_W-1:0] fpc_q, fpc_d;
  logic [PC_W-1:0] tag_q, tag_d;
  logic            inflight_q, inflight_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  ent_t            mem_q [DEPTH];
  ent_t            mem_d [DEPTH];

  logic            redir;
  logic [PC_W-1:0] tgt;
  logic [CW1-1:0]  credit;
  logic            issue;
  logic            enq;
  logic            deq;

  always_comb begin
    redir = int_req_i | ex_redirect_i | bp_token_i;
    if (int_req_i) begin
      tgt = int_pc_i;
    end else if (ex_redirect_i) begin
      tgt = ex_pc_i;
    end else begin
      tgt = bp_pc_i;
    end
  end

  // Credit counts the in-flight response so it always finds a free slot.
  assign credit = {1'b0, cnt_q} + CW1'(inflight_q);
  assign issue  = !redir && (credit < CW1'(DEPTH));
  assign enq    = inflight_q & !redir;
  assign deq    = id_valid_o & id_ready_i;

  assign irom_req_o = resetn & issue;
  assign irom_pc_o  = fpc_q;
  assign id_valid_o = (cnt_q != '0) & !redir;
  assign id_pc_o    = mem_q[rd_q].pc;
  assign id_inst_o  = mem_q[rd_q].inst;
  assign id_pc_4_o  = mem_q[rd_q].pc + PC_W'(PC_STEP);
  assign q_count_o  = cnt_q;

  always_comb begin
    fpc_d      = fpc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    if (redir) begin
      fpc_d = tgt;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (issue) begin
        fpc_d = fpc_q + PC_W'(PC_STEP);
        tag_d = fpc_q;
      end
      if (enq) begin
        mem_d[wr_q] = {tag_q, irom_inst_i};
        wr_d        = wr_q + AW'(1);
      end
      if (deq) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fpc_q      <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      fpc_q      <= fpc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-level reference model checked every
// cycle, plus directed literal expectations.
module tb_if_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RST   = 32'hbfc00000;
  localparam logic [31:0] KEY   = 32'h5a5a5a5a;

  logic        clk;
  logic        resetn;
  logic        irom_req_o;
  logic [31:0] irom_pc_o;
  logic [31:0] irom_inst_i;
  logic        int_req_i;
  logic [31:0] int_pc_i;
  logic        ex_redirect_i;
  logic [31:0] ex_pc_i;
  logic        bp_token_i;
  logic [31:0] bp_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_4_o;
  logic [31:0] id_inst_o;
  logic [2:0]  q_count_o;

  if_fetch_queue dut (
    .clk           (clk),
    .resetn        (resetn),
    .irom_req_o    (irom_req_o),
    .irom_pc_o     (irom_pc_o),
    .irom_inst_i   (irom_inst_i),
    .int_req_i     (int_req_i),
    .int_pc_i      (int_pc_i),
    .ex_redirect_i (ex_redirect_i),
    .ex_pc_i       (ex_pc_i),
    .bp_token_i    (bp_token_i),
    .bp_pc_i       (bp_pc_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_pc_o       (id_pc_o),
    .id_pc_4_o     (id_pc_4_o),
    .id_inst_o     (id_inst_o),
    .q_count_o     (q_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rom_addr;
  always @(posedge clk) rom_addr <= irom_pc_o;
  assign irom_inst_i = rom_addr ^ KEY;

  int n_chk;
  int n_fail;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc;
  logic [31:0] m_tag;
  int          m_infl;
  logic        m_redir;
  logic [31:0] m_tgt;
  logic        e_req;
  logic        e_valid;

  // Reference model: fetch PC, one pending response, a plain queue.
  always @(negedge clk) begin
    if (!resetn) begin
      m_fpc  = RST;
      m_tag  = '0;
      m_infl = 0;
      mq.delete();
      chk("rst_req", 32'(irom_req_o), 0);
      chk("rst_valid", 32'(id_valid_o), 0);
      chk("rst_cnt", 32'(q_count_o), 0);
      chk("rst_pc", id_pc_o, 0);
      chk("rst_inst", id_inst_o, 0);
    end else begin
      m_redir = int_req_i | ex_redirect_i | bp_token_i;
      m_tgt   = int_req_i ? int_pc_i :
                ex_redirect_i ? ex_pc_i : bp_pc_i;
      e_req   = !m_redir && (mq.size() + m_infl < DEPTH);
      e_valid = (mq.size() != 0) && !m_redir;
      chk("m_req", 32'(irom_req_o), 32'(e_req));
      chk("m_rompc", irom_pc_o, m_fpc);
      chk("m_valid", 32'(id_valid_o), 32'(e_valid));
      chk("m_cnt", 32'(q_count_o), 32'(mq.size()));
      if (e_valid) begin
        chk("m_pc", id_pc_o, mq[0].pc);
        chk("m_pc4", id_pc_4_o, mq[0].pc + 32'd4);
        chk("m_inst", id_inst_o, mq[0].inst);
      end
      if (m_redir) begin
        mq.delete();
        m_infl = 0;
        m_fpc  = m_tgt;
      end else begin
        if (e_valid && id_ready_i) void'(mq.pop_front());
        if (m_infl != 0) mq.push_back({m_tag, m_tag ^ KEY});
        m_infl = e_req ? 1 : 0;
        if (e_req) begin
          m_tag = m_fpc;
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    resetn        = 1'b0;
    id_ready_i    = 1'b1;
    int_req_i     = 1'b0;
    ex_redirect_i = 1'b0;
    bp_token_i    = 1'b0;
    int_pc_i      = '0;
    ex_pc_i       = '0;
    bp_pc_i       = '0;
    tick;
    tick;

    // 1: reset release, streaming
    resetn = 1'b1;
    #1;
    chk("t1_req0", 32'(irom_req_o), 1);
    chk("t1_pc0", irom_pc_o, 32'hbfc00000);
    tick;
    #1;
    chk("t1_pc1", irom_pc_o, 32'hbfc00004);
    chk("t1_nv1", 32'(id_valid_o), 0);
    tick;
    #1;
    chk("t1_v2", 32'(id_valid_o), 1);
    chk("t1_hpc", id_pc_o, 32'hbfc00000);
    chk("t1_hpc4", id_pc_4_o, 32'hbfc00004);
    chk("t1_hinst", id_inst_o, 32'hbfc00000 ^ KEY);
    tick;
    #1;
    chk("t1_hpc_n", id_pc_o, 32'hbfc00004);
    repeat (4) tick;

    // 2: stall fills the queue, then drains in order
    resetn = 1'b0;
    tick;
    id_ready_i = 1'b0;
    resetn     = 1'b1;
    repeat (10) tick;
    #1;
    chk("t2_cnt", 32'(q_count_o), 4);
    chk("t2_req", 32'(irom_req_o), 0);
    id_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_drain", id_pc_o, 32'hbfc00000 + 32'(4 * i));
      tick;
    end

    // 3: execute redirect with a partly full queue
    id_ready_i = 1'b0;
    repeat (3) tick;
    ex_redirect_i = 1'b1;
    ex_pc_i       = 32'h80001000;
    #1;
    chk("t3_nv", 32'(id_valid_o), 0);
    tick;
    ex_redirect_i = 1'b0;
    id_ready_i    = 1'b1;
    #1;
    chk("t3_cnt", 32'(q_count_o), 0);
    chk("t3_pc", irom_pc_o, 32'h80001000);
    chk("t3_req", 32'(irom_req_o), 1);
    tick;
    #1;
    chk("t3_nv2", 32'(id_valid_o), 0);
    tick;
    #1;
    chk("t3_v3", 32'(id_valid_o), 1);
    chk("t3_hpc", id_pc_o, 32'h80001000);
    repeat (3) tick;

    // 4: all three redirect sources together
    int_req_i     = 1'b1;
    ex_redirect_i = 1'b1;
    bp_token_i    = 1'b1;
    int_pc_i      = 32'hbfc00380;
    ex_pc_i       = 32'h80002000;
    bp_pc_i       = 32'h80003000;
    #1;
    chk("t4_nv", 32'(id_valid_o), 0);
    tick;
    int_req_i     = 1'b0;
    ex_redirect_i = 1'b0;
    bp_token_i    = 1'b0;
    #1;
    chk("t4_pc", irom_pc_o, 32'hbfc00380);
    tick;
    tick;
    #1;
    chk("t4_hpc", id_pc_o, 32'hbfc00380);
    repeat (2) tick;

    // 5: PC wrap
    bp_token_i = 1'b1;
    bp_pc_i    = 32'hfffffffc;
    tick;
    bp_token_i = 1'b0;
    #1;
    chk("t5_pc0", irom_pc_o, 32'hfffffffc);
    tick;
    #1;
    chk("t5_pc1", irom_pc_o, 32'h00000000);
    tick;
    #1;
    chk("t5_hpc", id_pc_o, 32'hfffffffc);
    chk("t5_hpc4", id_pc_4_o, 32'h00000000);
    repeat (3) tick;

    // 6: asynchronous reset with a full queue
    id_ready_i = 1'b0;
    repeat (8) tick;
    #1;
    chk("t6_full", 32'(q_count_o), 4);
    tick;
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_valid", 32'(id_valid_o), 0);
    chk("t6_cnt", 32'(q_count_o), 0);
    chk("t6_req", 32'(irom_req_o), 0);
    chk("t6_hpc", id_pc_o, 0);
    tick;
    tick;
    resetn     = 1'b1;
    id_ready_i = 1'b1;
    #1;
    chk("t6_pc", irom_pc_o, 32'hbfc00000);
    tick;
    tick;
    #1;
    chk("t6_head", id_pc_o, 32'hbfc00000);
    repeat (4) tick;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
